// File: rtl/fc_seq_pkg.sv
// Shared sizing and state encoding for the BNN fully-connected sequencer.
package fc_seq_pkg;
    localparam int DW    = 32;
    localparam int LANES = 6;
    localparam int N_IN  = 192;
    localparam int N_OUT = 10;
    localparam int WAW   = 11;
    localparam int FAW   = 5;
    localparam int TMO   = 64;
    localparam int BEATS = N_IN / LANES;
    localparam int CW    = 9;

    // Per-phase last-cycle values of the shared step counter.
    localparam logic [CW-1:0] LOAD_LAST = CW'(N_IN);
    localparam logic [CW-1:0] W_LAST    = CW'(N_IN - 1);
    localparam logic [CW-1:0] FEED_LAST = CW'(2 * BEATS - 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(TMO - 1);
    localparam logic [3:0]    N_LAST    = 4'(N_OUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_FEED,
        S_WAIT_OUT,
        S_DONE
    } state_t;
endpackage

// File: rtl/fc_seq_argmax.sv
// Running signed argmax over neuron results; first result seeds, ties keep the lower index.
module fc_seq_argmax
    import fc_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 vld,
    input  logic [3:0]           idx,
    input  logic signed [DW-1:0] data,
    output logic [3:0]           max_idx
);
    logic signed [DW-1:0] max_val;
    logic                 have;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_idx <= '0;
            max_val <= '0;
            have    <= 1'b0;
        end else if (clr) begin
            max_idx <= '0;
            max_val <= '0;
            have    <= 1'b0;
        end else if (vld && (!have || data > max_val)) begin
            max_idx <= idx;
            max_val <= data;
            have    <= 1'b1;
        end
    end
endmodule

// File: rtl/fc_seq.sv
// Sequencer for the BNN fc unit: weight load, gapped feature streaming, result capture, argmax.
module fc_seq
    import fc_seq_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [WAW-1:0]        w_addr,
    input  logic                  w_bit,
    output logic                  f_rd,
    output logic [FAW-1:0]        f_addr,
    input  logic [LANES*DW-1:0]   f_data,
    output logic                  fc_weight,
    output logic                  fc_weight_en,
    output logic                  fc_ivalid,
    output logic [LANES*DW-1:0]   fc_din,
    input  logic                  fc_ovalid,
    input  logic [DW-1:0]         fc_dout,
    output logic                  res_valid,
    output logic [3:0]            res_idx,
    output logic [DW-1:0]         res_data,
    output logic                  class_valid,
    output logic [3:0]            class_out
);
    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    n;
    logic          start_ok;

    assign start_ok  = (state == S_IDLE) && start;
    assign fc_weight = fc_weight_en & w_bit;
    assign fc_din    = f_data;

    // Outputs are loaded one edge ahead so each reflects the phase cycle it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            n            <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            w_addr       <= '0;
            fc_weight_en <= 1'b0;
            f_rd         <= 1'b0;
            f_addr       <= '0;
            fc_ivalid    <= 1'b0;
            res_valid    <= 1'b0;
            res_idx      <= '0;
            res_data     <= '0;
            class_valid  <= 1'b0;
        end else begin
            done        <= 1'b0;
            class_valid <= 1'b0;
            res_valid   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_LOAD_W;
                        busy   <= 1'b1;
                        err    <= 1'b0;
                        cnt    <= '0;
                        n      <= '0;
                        w_addr <= '0;
                    end
                end
                S_LOAD_W: begin
                    if (cnt == LOAD_LAST) begin
                        state        <= S_FEED;
                        cnt          <= '0;
                        fc_weight_en <= 1'b0;
                        f_rd         <= 1'b1;
                        f_addr       <= '0;
                    end else begin
                        cnt          <= cnt + 1'b1;
                        fc_weight_en <= 1'b1;
                        if (cnt != W_LAST)
                            w_addr <= w_addr + 1'b1;
                    end
                end
                S_FEED: begin
                    // Even cycles read the buffer, odd cycles present the beat to fc.
                    if (cnt == FEED_LAST) begin
                        state     <= S_WAIT_OUT;
                        cnt       <= '0;
                        f_rd      <= 1'b0;
                        fc_ivalid <= 1'b0;
                    end else begin
                        cnt       <= cnt + 1'b1;
                        f_rd      <= cnt[0];
                        fc_ivalid <= ~cnt[0];
                        if (cnt[0])
                            f_addr <= f_addr + 1'b1;
                    end
                end
                S_WAIT_OUT: begin
                    if (res_valid) begin
                        if (n == N_LAST) begin
                            state       <= S_DONE;
                            done        <= 1'b1;
                            class_valid <= 1'b1;
                        end else begin
                            state  <= S_LOAD_W;
                            n      <= n + 1'b1;
                            cnt    <= '0;
                            w_addr <= w_addr + 1'b1;
                        end
                    end else if (fc_ovalid) begin
                        res_valid <= 1'b1;
                        res_idx   <= n;
                        res_data  <= fc_dout;
                    end else if (cnt == TMO_LAST) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    fc_seq_argmax u_argmax (
        .clk     (clk),
        .rst     (rst),
        .clr     (start_ok),
        .vld     (res_valid),
        .idx     (res_idx),
        .data    (res_data),
        .max_idx (class_out)
    );
endmodule

// File: tb/tb_fc_seq.sv
// Directed bench for fc_seq with weight ROM, feature buffer and fc responder models.
module tb_fc_seq;
    import fc_seq_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start = 1'b0;
    logic                 busy, done, err;
    logic [WAW-1:0]       w_addr;
    logic                 w_bit = 1'b0;
    logic                 f_rd;
    logic [FAW-1:0]       f_addr;
    logic [LANES*DW-1:0]  f_data = '0;
    logic                 fc_weight, fc_weight_en, fc_ivalid;
    logic [LANES*DW-1:0]  fc_din;
    logic                 fc_ovalid = 1'b0;
    logic [DW-1:0]        fc_dout = '0;
    logic                 res_valid;
    logic [3:0]           res_idx;
    logic [DW-1:0]        res_data;
    logic                 class_valid;
    logic [3:0]           class_out;

    fc_seq dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
        .w_addr(w_addr), .w_bit(w_bit), .f_rd(f_rd), .f_addr(f_addr), .f_data(f_data),
        .fc_weight(fc_weight), .fc_weight_en(fc_weight_en), .fc_ivalid(fc_ivalid),
        .fc_din(fc_din), .fc_ovalid(fc_ovalid), .fc_dout(fc_dout),
        .res_valid(res_valid), .res_idx(res_idx), .res_data(res_data),
        .class_valid(class_valid), .class_out(class_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    bit          rom [0:2047];
    logic [31:0] resp [10];
    int          hold_n = -1;
    logic        stray_ov = 1'b0;
    logic        model_clr = 1'b0;
    logic        mon_clr = 1'b0;
    int          ivc = 0;
    int          nresp = 0;

    function automatic logic [LANES*DW-1:0] beatWord(input int b);
        logic [DW-1:0] w;
        w = DW'(b);
        return {LANES{w}};
    endfunction

    // Synchronous ROM and feature buffer, one cycle of read latency each.
    always @(posedge clk) begin
        w_bit <= rom[w_addr];
        if (f_rd)
            f_data <= beatWord(int'(f_addr));
    end

    // fc responder: one result the cycle after every BEATS-th ivalid unless withheld.
    always @(posedge clk or posedge rst) begin
        if (rst || model_clr) begin
            ivc       <= 0;
            nresp     <= 0;
            fc_ovalid <= 1'b0;
        end else begin
            fc_ovalid <= stray_ov;
            if (stray_ov)
                fc_dout <= 32'h7fff_ffff;
            if (fc_ivalid) begin
                if (ivc == BEATS - 1) begin
                    ivc   <= 0;
                    nresp <= nresp + 1;
                    if (nresp != hold_n) begin
                        fc_ovalid <= 1'b1;
                        fc_dout   <= resp[nresp % 10];
                    end
                end else begin
                    ivc <= ivc + 1;
                end
            end
        end
    end

    int             exp_addr, waddr_err, wbit_err, run_len, en_runs, en_err;
    int             beat, iv_cnt, consec_err, din_err, res_cnt, done_cnt;
    logic [WAW-1:0] prev_waddr;
    logic           prev_en, prev_iv;
    logic [31:0]    res_data_log [10];
    logic [3:0]     res_idx_log [10];
    logic [3:0]     done_class;
    logic           done_cv, done_err;

    always begin
        @(posedge clk);
        #3;
        if (mon_clr) begin
            exp_addr = 0; waddr_err = 0; wbit_err = 0; run_len = 0; en_runs = 0; en_err = 0;
            beat = 0; iv_cnt = 0; consec_err = 0; din_err = 0; res_cnt = 0; done_cnt = 0;
            done_class = '0; done_cv = 1'b0; done_err = 1'b0;
        end else begin
            if (fc_weight_en) begin
                if (prev_waddr !== WAW'(exp_addr)) waddr_err++;
                if (fc_weight !== rom[prev_waddr]) wbit_err++;
                exp_addr++;
                run_len++;
            end else if (prev_en) begin
                if (run_len != N_IN) en_err++;
                en_runs++;
                run_len = 0;
            end
            if (fc_ivalid) begin
                if (prev_iv) consec_err++;
                if (fc_din !== beatWord(beat)) din_err++;
                beat = (beat + 1) % BEATS;
                iv_cnt++;
            end
            if (res_valid) begin
                if (res_cnt < 10) begin
                    res_idx_log[res_cnt]  = res_idx;
                    res_data_log[res_cnt] = res_data;
                end
                res_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_class = class_out;
                done_cv    = class_valid;
                done_err   = err;
            end
        end
        prev_waddr = w_addr;
        prev_en    = fc_weight_en;
        prev_iv    = fc_ivalid;
    end

    int   lat;
    logic busy_at_start, err_at_start, busy_after, done_after, err_after;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic setResp(input int v0, input int v1, input int v2, input int v3, input int v4,
                           input int v5, input int v6, input int v7, input int v8, input int v9);
        resp[0] = v0; resp[1] = v1; resp[2] = v2; resp[3] = v3; resp[4] = v4;
        resp[5] = v5; resp[6] = v6; resp[7] = v7; resp[8] = v8; resp[9] = v9;
    endtask

    task automatic applyStimulus(input int abort_lat, input int feed_start_lat,
                                 input int stray_lat, input bit start_in_done);
        @(negedge clk);
        start = 1'b1; mon_clr = 1'b1; model_clr = 1'b1;
        @(negedge clk);
        start = 1'b0; mon_clr = 1'b0; model_clr = 1'b0;
        lat = 1;
        busy_at_start = busy;
        err_at_start  = err;
        while (!done && lat < 4000) begin
            if (lat == abort_lat) begin
                rst = 1'b1;
                #1;
                checkOutput("rst_ctrl", {busy, done, err, class_valid, res_valid, fc_weight_en,
                                         fc_weight, fc_ivalid, f_rd}, 0);
                checkOutput("rst_addr", {w_addr, f_addr, class_out, res_idx}, 0);
                checkOutput("rst_res_data", res_data, 0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            @(negedge clk);
            lat++;
            start    = (lat == feed_start_lat);
            stray_ov = (lat == stray_lat);
        end
        start    = 1'b0;
        stray_ov = 1'b0;
        if (!done) begin
            checkOutput("done_seen", 0, 1);
            return;
        end
        if (start_in_done) start = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        busy_after = busy;
        done_after = done;
        err_after  = err;
    endtask

    task automatic checkRun(input string tag, input int exp_lat, input int exp_nres, input int exp_neur,
                            input int exp_class, input bit exp_cv, input bit exp_err);
        checkOutput({tag, "_latency"}, lat, exp_lat);
        checkOutput({tag, "_busy_at_start"}, busy_at_start, 1);
        checkOutput({tag, "_err_at_start"}, err_at_start, 0);
        checkOutput({tag, "_res_count"}, res_cnt, exp_nres);
        for (int i = 0; i < exp_nres && i < 10; i++) begin
            checkOutput({tag, "_res_idx"}, res_idx_log[i], i);
            checkOutput({tag, "_res_data"}, res_data_log[i], resp[i]);
        end
        checkOutput({tag, "_done_count"}, done_cnt, 1);
        checkOutput({tag, "_class_out"}, done_class, exp_class);
        checkOutput({tag, "_class_valid"}, done_cv, exp_cv);
        checkOutput({tag, "_err_at_done"}, done_err, exp_err);
        checkOutput({tag, "_busy_after"}, busy_after, 0);
        checkOutput({tag, "_done_after"}, done_after, 0);
        checkOutput({tag, "_err_after"}, err_after, exp_err);
        checkOutput({tag, "_waddr_seq"}, waddr_err, 0);
        checkOutput({tag, "_wbit"}, wbit_err, 0);
        checkOutput({tag, "_waddr_end"}, exp_addr, exp_neur * N_IN);
        checkOutput({tag, "_en_runs"}, en_runs, exp_neur);
        checkOutput({tag, "_en_len"}, en_err, 0);
        checkOutput({tag, "_ivalid_count"}, iv_cnt, exp_neur * BEATS);
        checkOutput({tag, "_ivalid_gap"}, consec_err, 0);
        checkOutput({tag, "_din"}, din_err, 0);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            int v;
            v = i * 37 + (i >> 2);
            rom[i] = v[0] ^ v[3] ^ v[5];
        end
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_ctrl", {busy, done, err, class_valid, res_valid, fc_weight_en,
                                   fc_ivalid, f_rd}, 0);
        checkOutput("reset_addr", {w_addr, f_addr, class_out}, 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] run: nominal results");
        setResp(5, -3, 7, 7, 0, 1, 2, -8, 6, 4);
        applyStimulus(0, 0, 0, 1'b0);
        checkRun("nominal", 2591, 10, 10, 2, 1'b1, 1'b0);

        $display("[TB] run: all results equal");
        setResp(-100, -100, -100, -100, -100, -100, -100, -100, -100, -100);
        applyStimulus(0, 0, 0, 1'b0);
        checkRun("equal", 2591, 10, 10, 0, 1'b1, 1'b0);

        $display("[TB] run: neuron 3 withheld");
        hold_n = 3;
        applyStimulus(0, 0, 0, 1'b0);
        hold_n = -1;
        checkRun("timeout", 1099, 3, 4, 0, 1'b0, 1'b1);

        $display("[TB] run: stray start and ovalid");
        setResp(5, -3, 7, 7, 0, 1, 2, -8, 6, 4);
        applyStimulus(0, 200, 50, 1'b1);
        checkRun("stray", 2591, 10, 10, 2, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("stray_idle_busy", busy, 0);
        checkOutput("stray_res_after", res_cnt, 10);

        $display("[TB] run: reset mid-feed then restart");
        applyStimulus(1250, 0, 0, 1'b0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 1'b0);
        checkRun("restart", 2591, 10, 10, 2, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
